// File: rtl/pong_ball_engine_if.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_engine_if
// Description : Frame/serve/paddle inputs and ball/score outputs of the engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface pong_ball_engine_if;
    logic       frame_tick;
    logic       serve;
    logic [4:0] paddle_y;
    logic [4:0] ball_x;
    logic [4:0] ball_y;
    logic       playing;
    logic       miss;
    logic [7:0] hit_count;
    logic [7:0] miss_count;

    modport master (
        output frame_tick, serve, paddle_y,
        input  ball_x, ball_y, playing, miss, hit_count, miss_count
    );

    modport slave (
        input  frame_tick, serve, paddle_y,
        output ball_x, ball_y, playing, miss, hit_count, miss_count
    );
endinterface
`default_nettype wire

// File: rtl/pong_ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : pong_ball_engine
// Description : Pong ball motion, wall/paddle bounce, serve/miss FSM, scores.
// Revision    : 1.0 - initial release
// ============================================================================
module pong_ball_engine #(
    parameter int GRID_W       = 32,
    parameter int GRID_H       = 24,
    parameter int PADDLE_X     = 3,
    parameter int PADDLE_LEN   = 5,
    parameter int SPEED_FRAMES = 4,
    parameter int MISS_FRAMES  = 60,
    parameter int START_X      = 5,
    parameter int START_Y      = 5
) (
    input  logic              clk,
    input  logic              rst,
    pong_ball_engine_if.slave bus
);
    localparam int FC_W = (SPEED_FRAMES > 1) ? $clog2(SPEED_FRAMES) : 1;
    localparam int MC_W = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_MISS = 2'd2;

    localparam logic [4:0]      c_start_x    = 5'(START_X);
    localparam logic [4:0]      c_start_y    = 5'(START_Y);
    localparam logic [4:0]      c_right_col  = 5'(GRID_W - 1);
    localparam logic [4:0]      c_bottom_row = 5'(GRID_H - 1);
    localparam logic [4:0]      c_paddle_col = 5'(PADDLE_X + 1);
    localparam logic [5:0]      c_paddle_ext = 6'(PADDLE_LEN - 1);
    localparam logic [FC_W-1:0] c_frame_last = FC_W'(SPEED_FRAMES - 1);
    localparam logic [MC_W-1:0] c_miss_last  = MC_W'(MISS_FRAMES - 1);

    logic [1:0]      r_state,      w_state_nxt;
    logic [4:0]      r_ball_x,     w_ball_x_nxt;
    logic [4:0]      r_ball_y,     w_ball_y_nxt;
    logic            r_dir_right,  w_dir_right_nxt;
    logic            r_dir_down,   w_dir_down_nxt;
    logic [FC_W-1:0] r_frame_cnt,  w_frame_cnt_nxt;
    logic [MC_W-1:0] r_miss_ticks, w_miss_ticks_nxt;
    logic [7:0]      r_hit_count,  w_hit_count_nxt;
    logic [7:0]      r_miss_count, w_miss_count_nxt;
    logic            r_miss,       w_miss_nxt;

    // Widened to 6 bits so paddle_y + PADDLE_LEN - 1 cannot wrap past row 31.
    logic [5:0] w_pad_lo, w_pad_hi, w_ball_y6;
    logic       w_at_paddle, w_at_left;

    assign w_pad_lo    = {1'b0, bus.paddle_y};
    assign w_pad_hi    = w_pad_lo + c_paddle_ext;
    assign w_ball_y6   = {1'b0, r_ball_y};
    assign w_at_paddle = !r_dir_right && (r_ball_x == c_paddle_col) &&
                         (w_ball_y6 >= w_pad_lo) && (w_ball_y6 <= w_pad_hi);
    assign w_at_left   = !r_dir_right && (r_ball_x == 5'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_ball_x     <= c_start_x;
            r_ball_y     <= c_start_y;
            r_dir_right  <= 1'b1;
            r_dir_down   <= 1'b1;
            r_frame_cnt  <= '0;
            r_miss_ticks <= '0;
            r_hit_count  <= 8'd0;
            r_miss_count <= 8'd0;
            r_miss       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_ball_x     <= w_ball_x_nxt;
            r_ball_y     <= w_ball_y_nxt;
            r_dir_right  <= w_dir_right_nxt;
            r_dir_down   <= w_dir_down_nxt;
            r_frame_cnt  <= w_frame_cnt_nxt;
            r_miss_ticks <= w_miss_ticks_nxt;
            r_hit_count  <= w_hit_count_nxt;
            r_miss_count <= w_miss_count_nxt;
            r_miss       <= w_miss_nxt;
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_ball_x_nxt     = r_ball_x;
        w_ball_y_nxt     = r_ball_y;
        w_dir_right_nxt  = r_dir_right;
        w_dir_down_nxt   = r_dir_down;
        w_frame_cnt_nxt  = r_frame_cnt;
        w_miss_ticks_nxt = r_miss_ticks;
        w_hit_count_nxt  = r_hit_count;
        w_miss_count_nxt = r_miss_count;
        w_miss_nxt       = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_ball_x_nxt    = c_start_x;
                w_ball_y_nxt    = c_start_y;
                w_dir_right_nxt = 1'b1;
                w_dir_down_nxt  = 1'b1;
                if (bus.serve) begin
                    w_state_nxt     = S_PLAY;
                    w_frame_cnt_nxt = '0;
                end
            end
            S_PLAY: begin
                if (bus.frame_tick) begin
                    if (r_frame_cnt != c_frame_last) begin
                        w_frame_cnt_nxt = r_frame_cnt + 1'b1;
                    end else begin
                        w_frame_cnt_nxt = '0;
                        if (w_at_left) begin
                            // Ball leaves the field: freeze both axes where it is.
                            w_state_nxt      = S_MISS;
                            w_miss_nxt       = 1'b1;
                            w_miss_ticks_nxt = '0;
                            if (r_miss_count != 8'hFF)
                                w_miss_count_nxt = r_miss_count + 8'd1;
                        end else begin
                            if (r_dir_right) begin
                                if (r_ball_x == c_right_col) begin
                                    w_dir_right_nxt = 1'b0;
                                    w_ball_x_nxt    = r_ball_x - 5'd1;
                                end else begin
                                    w_ball_x_nxt    = r_ball_x + 5'd1;
                                end
                            end else if (w_at_paddle) begin
                                w_dir_right_nxt = 1'b1;
                                w_ball_x_nxt    = r_ball_x + 5'd1;
                                if (r_hit_count != 8'hFF)
                                    w_hit_count_nxt = r_hit_count + 8'd1;
                            end else begin
                                w_ball_x_nxt    = r_ball_x - 5'd1;
                            end

                            if (r_dir_down) begin
                                if (r_ball_y == c_bottom_row) begin
                                    w_dir_down_nxt = 1'b0;
                                    w_ball_y_nxt   = r_ball_y - 5'd1;
                                end else begin
                                    w_ball_y_nxt   = r_ball_y + 5'd1;
                                end
                            end else if (r_ball_y == 5'd0) begin
                                w_dir_down_nxt = 1'b1;
                                w_ball_y_nxt   = r_ball_y + 5'd1;
                            end else begin
                                w_ball_y_nxt   = r_ball_y - 5'd1;
                            end
                        end
                    end
                end
            end
            S_MISS: begin
                if (bus.frame_tick) begin
                    if (r_miss_ticks == c_miss_last) begin
                        w_state_nxt      = S_IDLE;
                        w_miss_ticks_nxt = '0;
                        w_ball_x_nxt     = c_start_x;
                        w_ball_y_nxt     = c_start_y;
                        w_dir_right_nxt  = 1'b1;
                        w_dir_down_nxt   = 1'b1;
                    end else begin
                        w_miss_ticks_nxt = r_miss_ticks + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.ball_x     = r_ball_x;
    assign bus.ball_y     = r_ball_y;
    assign bus.playing    = (r_state == S_PLAY);
    assign bus.miss       = r_miss;
    assign bus.hit_count  = r_hit_count;
    assign bus.miss_count = r_miss_count;
endmodule
`default_nettype wire

// File: doc/pong_ball_engine.md
Name: pong_ball_engine

Overview:
Game-logic stage that sits directly upstream of the Pong renderer and produces the ball's grid coordinates (20-pixel cells, 32x24 playfield) that the renderer draws. It advances the ball once every SPEED_FRAMES frame ticks. It bounces the ball off the top, bottom and right walls and off the paddle. When the ball leaves past the left edge, it detects the miss. It also runs a serve/miss state machine and keeps hit and miss counters for later score display.

Parameters:
GRID_W, 32, playfield width in cells
GRID_H, 24, playfield height in cells
PADDLE_X, 3, paddle column (cells)
PADDLE_LEN, 5, paddle height in cells
SPEED_FRAMES, 4, frame ticks per ball step (>=1)
MISS_FRAMES, 60, frame ticks spent in MISS before returning to IDLE
START_X, 5, serve column
START_Y, 5, serve row

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per video frame (from vertical counter wrap)
serve  in  1  one-cycle pulse; launches ball when IDLE
paddle_y  in  5  paddle top row in cells (covers paddle_y..paddle_y+PADDLE_LEN-1)
ball_x  out  5  ball column, registered
ball_y  out  5  ball row, registered
playing  out  1  high while state is PLAY
miss  out  1  one-cycle pulse on entry to MISS
hit_count  out  8  paddle hits, saturates at 255
miss_count  out  8  misses, saturates at 255

Behaviour:
- Reset (rst=1 at clk edge): ball_x=START_X, ball_y=START_Y, dir_x=right, dir_y=down, state=IDLE, frame counter=0, playing=0, miss=0, hit_count=0, miss_count=0.
- rst has priority over all other inputs, including mid-PLAY or mid-MISS.
- States:
  - IDLE: ball held at (START_X,START_Y) with dir right/down. serve=1 -> PLAY, frame counter cleared. A frame_tick in the same cycle is ignored.
  - PLAY: on frame_tick, if frame counter==SPEED_FRAMES-1, perform a step and clear the counter; otherwise increment the counter. serve is ignored.
  - MISS: ball frozen at its last position. Count frame_ticks; on the MISS_FRAMES-th tick -> IDLE, ball reloads the start position and directions. serve is ignored.
- Step rules, evaluated on the current registered ball_x/ball_y, dir and paddle_y sampled in the step cycle:
  - X, moving right, ball_x==GRID_W-1: dir_x<=left, ball_x<=ball_x-1.
  - X, moving left, ball_x==PADDLE_X+1 and paddle_y<=ball_y<=paddle_y+PADDLE_LEN-1: dir_x<=right, ball_x<=ball_x+1, hit_count++ (saturating).
  - X, moving left, ball_x==0: no move. -> MISS, miss=1 for one cycle, miss_count++ (saturating). The Y update is also suppressed.
  - X, otherwise: ball_x +/- 1.
  - Y, moving down, ball_y==GRID_H-1: dir_y<=up, y-1.
  - Y, moving up, ball_y==0: dir_y<=down, y+1.
  - Y, otherwise: y +/- 1.
  - X and Y reflections are independent; a corner reverses both in the same step.
  - A missed paddle lets the ball continue left through columns PADDLE_X..0.
- Latency: new position is visible on outputs one clk after the qualifying frame_tick cycle.
- Coordinates never leave 0..GRID_W-1 / 0..GRID_H-1.
- The paddle comparison uses 6-bit arithmetic, so paddle_y+PADDLE_LEN does not wrap.

Test Plan:
1. Reset then serve, SPEED_FRAMES=1 -> after 1 tick (6,6); after 18 ticks (23,23); tick 19 gives (24,22) with dir_y=up.
2. SPEED_FRAMES=4, serve, 3 ticks -> ball still (5,5); 4th tick -> (6,6) one clk later.
3. SPEED_FRAMES=1, continue scenario 1 -> tick 26 (31,15); tick 27 (30,14) with dir_x=left.
4. SPEED_FRAMES=1, paddle_y=12, continue -> tick 53 (4,12); tick 54 (5,13), hit_count=1.
5. Same as 4 with paddle_y=0 -> tick 54 (3,13); tick 57 (0,16); tick 58: miss pulse, state MISS, miss_count=1, ball frozen.
6. In MISS, MISS_FRAMES=60 ticks -> IDLE with ball (5,5). serve during MISS is ignored. rst asserted mid-PLAY -> all outputs at reset values next clk.
